// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the fetch port and the load/store port
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   inst_req/inst_addr                 fetch request in
//   inst_addr_ok/data_ok/rdata         fetch accept, response valid, read data
//   data_req/wr/wstrb/addr/wdata       load/store request in
//   data_addr_ok/data_ok/rdata         load/store accept, response valid, load data
//   sram_en/we/addr/wdata, sram_rdata  SRAM macro interface (read data one cycle after enable)
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);
    typedef enum logic [1:0] {NONE, INST, DATA} resp_t;

    resp_t      resp;
    logic       resp_load;
    logic [3:0] starve_cnt;
    logic       force_inst;
    logic       inst_gnt;
    logic       data_gnt;

    // Data normally wins; once fetch has been passed over STARVE_MAX times in a row it takes the port.
    assign force_inst = starve_cnt == 4'(STARVE_MAX);
    assign inst_gnt   = resetn && inst_req && (!data_req || force_inst);
    assign data_gnt   = resetn && data_req && !inst_gnt;

    assign inst_addr_ok = inst_gnt;
    assign data_addr_ok = data_gnt;
    assign sram_en      = inst_gnt || data_gnt;
    assign sram_we      = (data_gnt && data_wr) ? data_wstrb : 4'b0;
    assign sram_addr    = !resetn ? 32'b0 : inst_gnt ? inst_addr : data_addr;
    assign sram_wdata   = resetn ? data_wdata : 32'b0;

    assign inst_data_ok = resp == INST;
    assign data_data_ok = resp == DATA;
    assign inst_rdata   = inst_data_ok ? sram_rdata : 32'b0;
    assign data_rdata   = (data_data_ok && resp_load) ? sram_rdata : 32'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= 4'b0;
            resp       <= NONE;
            resp_load  <= 1'b0;
        end else begin
            resp      <= inst_gnt ? INST : data_gnt ? DATA : NONE;
            resp_load <= data_gnt && !data_wr;
            if (inst_gnt || !inst_req)
                starve_cnt <= 4'b0;
            else if (data_gnt && !force_inst)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests with a behavioural arbiter/memory model checked every cycle
module tb_mem_port_arbiter;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = 32'b0;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    logic [31:0] iq[$];
    dreq_t       dq[$];
    logic        acc_i = 1'b0, acc_d = 1'b0;
    int          n_cmp = 0, n_err = 0;

    logic [31:0] sram_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int          own_log[$];
    logic [31:0] ird_log[$], drd_log[$];
    logic [3:0]  we_log[$];
    byte         glog[$];
    bit          log_on = 1'b0;

    function automatic logic [31:0] init_word(logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM macro: synchronous read, byte-enabled write
    always @(posedge clk) begin : sram
        logic [31:0] cur;
        if (sram_en) begin
            cur = sram_mem.exists(sram_addr >> 2) ? sram_mem[sram_addr >> 2] : init_word(sram_addr);
            sram_rdata <= cur;
            if (sram_we != 4'b0) sram_mem[sram_addr >> 2] = merge(cur, sram_wdata, sram_we);
        end
    end

    // Requesters: present the head of each queue, holding it until accepted
    initial begin
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        forever begin
            @(posedge clk);
            if (acc_i && iq.size() != 0) void'(iq.pop_front());
            if (acc_d && dq.size() != 0) void'(dq.pop_front());
            #1;
            inst_req  = iq.size() != 0;
            inst_addr = inst_req ? iq[0] : 32'b0;
            data_req  = dq.size() != 0;
            if (data_req) {data_wr, data_wstrb, data_addr, data_wdata} = dq[0];
            else {data_wr, data_wstrb, data_addr, data_wdata} = '0;
        end
    end

    // Model: m_wait = consecutive cycles fetch was refused; m_pend = owner of last grant
    int          m_wait = 0, m_pend = 0, d_wait = 0;
    logic        m_ld = 1'b0;
    logic [31:0] m_rd = 32'b0;

    always @(negedge clk) begin : cmp
        logic        eig, edg;
        logic [31:0] a, cur;
        acc_i = inst_req && inst_addr_ok;
        acc_d = data_req && data_addr_ok;
        if (inst_data_ok) begin own_log.push_back(1); ird_log.push_back(inst_rdata); end
        if (data_data_ok) begin own_log.push_back(2); drd_log.push_back(data_rdata); end
        if (sram_we != 4'b0) we_log.push_back(sram_we);
        if (log_on && (inst_addr_ok || data_addr_ok)) glog.push_back(inst_addr_ok ? "I" : "D");
        if (inst_addr_ok) begin
            chk("inst_wait_bound", 32'(d_wait <= SM), 1);
            d_wait = 0;
        end else begin
            d_wait = inst_req ? d_wait + 1 : 0;
        end
        if (!resetn) begin
            chk("rst_flags", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we}, 0);
            chk("rst_sram_addr", sram_addr, 0);
            chk("rst_sram_wdata", sram_wdata, 0);
            chk("rst_rdata", inst_rdata | data_rdata, 0);
            chk("rst_starve", 32'(dut.starve_cnt), 0);
            m_wait = 0; m_pend = 0; m_ld = 1'b0;
        end else begin
            eig = inst_req && (!data_req || m_wait >= SM);
            edg = data_req && !eig;
            chk("inst_addr_ok", inst_addr_ok, eig);
            chk("data_addr_ok", data_addr_ok, edg);
            chk("sram_en", sram_en, eig || edg);
            chk("sram_we", sram_we, (edg && data_wr) ? data_wstrb : 4'b0);
            if (eig || edg) chk("sram_addr", sram_addr, eig ? inst_addr : data_addr);
            chk("sram_wdata", sram_wdata, data_wdata);
            chk("inst_data_ok", inst_data_ok, m_pend == 1);
            chk("data_data_ok", data_data_ok, m_pend == 2);
            chk("inst_rdata", inst_rdata, m_pend == 1 ? m_rd : 32'b0);
            chk("data_rdata", data_rdata, (m_pend == 2 && m_ld) ? m_rd : 32'b0);
            chk("starve_cnt", 32'(dut.starve_cnt), m_wait);
            a   = eig ? inst_addr : data_addr;
            cur = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : init_word(a);
            if (edg && data_wr) ref_mem[a >> 2] = merge(cur, data_wdata, data_wstrb);
            m_pend = eig ? 1 : edg ? 2 : 0;
            m_ld   = edg && !data_wr;
            m_rd   = cur;
            m_wait = (inst_req && !eig) ? m_wait + 1 : 0;
        end
    end

    task automatic clear_logs();
        own_log.delete(); ird_log.delete(); drd_log.delete(); we_log.delete(); glog.delete();
    endtask

    task automatic drain(int lim);
        int n = 0;
        while ((iq.size() != 0 || dq.size() != 0) && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < lim), 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string pat;
        int    n;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // fetch-only stream
        clear_logs();
        @(negedge clk);
        iq.push_back(32'h1c00_0000); iq.push_back(32'h1c00_0004); iq.push_back(32'h1c00_0008);
        drain(50);
        chk("inst_stream_n", ird_log.size(), 3);
        if (ird_log.size() == 3) begin
            chk("inst_rd0", ird_log[0], 32'hC2AD_0000);
            chk("inst_rd1", ird_log[1], 32'hC2AD_0004);
            chk("inst_rd2", ird_log[2], 32'hC2AD_0008);
        end

        // same-cycle conflict: data first, fetch next
        clear_logs();
        @(negedge clk);
        iq.push_back(32'h1c00_0000);
        dq.push_back('{1'b0, 4'b0, 32'h0000_0100, 32'b0});
        drain(50);
        chk("conflict_n", own_log.size(), 2);
        if (own_log.size() == 2) begin
            chk("conflict_first_owner", own_log[0], 2);
            chk("conflict_second_owner", own_log[1], 1);
            chk("conflict_load", drd_log[0], 32'hDEAD_0100);
            chk("conflict_fetch", ird_log[0], 32'hC2AD_0000);
        end

        // starvation: both ports busy
        clear_logs();
        @(negedge clk);
        log_on = 1'b1;
        for (int k = 0; k < 4; k++) iq.push_back(32'h1c00_0010 + 32'(4 * k));
        for (int k = 0; k < 14; k++) dq.push_back('{1'b0, 4'b0, 32'h0000_0400 + 32'(4 * k), 32'b0});
        drain(100);
        log_on = 1'b0;
        pat = "DDDDIDDDDIDDDDI";
        chk("grant_log_n", 32'(glog.size() >= 15), 1);
        for (int i = 0; i < 15; i++)
            if (i < glog.size()) chk($sformatf("grant_seq%0d", i), 32'(glog[i]), 32'(pat[i]));

        // partial store, zero-strobe store, read back
        clear_logs();
        @(negedge clk);
        dq.push_back('{1'b1, 4'b0011, 32'h0000_0200, 32'hAABB_CCDD});
        dq.push_back('{1'b1, 4'b0000, 32'h0000_0204, 32'h1234_5678});
        dq.push_back('{1'b0, 4'b0, 32'h0000_0200, 32'b0});
        dq.push_back('{1'b0, 4'b0, 32'h0000_0204, 32'b0});
        drain(50);
        chk("store_we_n", we_log.size(), 1);
        if (we_log.size() == 1) chk("store_we", we_log[0], 4'b0011);
        chk("store_acks", drd_log.size(), 4);
        if (drd_log.size() == 4) begin
            chk("store_ack_rdata", drd_log[0] | drd_log[1], 0);
            chk("load_after_partial", drd_log[2], 32'hDEAD_CCDD);
            chk("load_after_nostrb", drd_log[3], 32'hDEAD_0204);
        end

        // reset while a load response is pending
        clear_logs();
        @(negedge clk);
        dq.push_back('{1'b0, 4'b0, 32'h0000_0300, 32'b0});
        n = 0;
        do begin @(posedge clk); n++; end while (!acc_d && n < 20);
        chk("rst_accept_timeout", 32'(n < 20), 1);
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        chk("rst_dropped_resp", own_log.size(), 0);
        @(negedge clk);
        dq.push_back('{1'b0, 4'b0, 32'h0000_0300, 32'b0});
        drain(50);
        chk("post_rst_n", drd_log.size(), 1);
        if (drd_log.size() == 1) chk("post_rst_load", drd_log[0], 32'hDEAD_0300);

        // idle
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        chk("idle_en", sram_en, 0);
        chk("idle_starve", 32'(dut.starve_cnt), 0);
        chk("idle_resps", own_log.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
